ntt_scatter_buffer: RTL and testbench
=====================================

# ntt_scatter_buffer

Scatter buffer that accepts one N-bit coefficient per handshake, writes it into an addressed slot of an S-slot register bank, and presents the whole bank as one packed parallel vector once every slot has been written. It is the write-side counterpart of the tree multiplexer: the mux selects one word out of a packed S-word bus, and this block assembles that packed bus from individually addressed words. It sits between the serial coefficient loader and the parallel butterfly array and memory-select logic.

## Interface
- N, 64, coefficient width in bits.
- S, 64, number of slots (S ≥ 2); AW = $clog2(S); P = 2**AW.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of fill tracking; highest priority after reset.
- in_valid  in  1  write request.
- in_ready  out  1  buffer accepts writes.
- in_addr  in  AW  target slot.
- in_data  in  N  coefficient.
- out_valid  out  1  all S slots written; vector stable.
- out_ready  in  1  consumer takes vector.
- out_data  out  P*N  packed bank; slot k at out_data[N*k +: N]; slots S..P-1 are constant 0.
- fill_count  out  AW+1  number of distinct slots written in the current frame.
- addr_err  out  1  one-cycle pulse: accepted write had in_addr ≥ S.

## Operation
- State FILL: in_ready=1, out_valid=0. State FULL: in_ready=0, out_valid=1.
- Accept = in_valid && in_ready. On accept with in_addr < S: bank[in_addr] ← in_data; if written[in_addr]=0, set it and increment fill_count; otherwise overwrite the data without changing the count.
- On accept with in_addr ≥ S (only possible when S is not a power of two): data is dropped, no state change, addr_err=1 on the next cycle.
- FILL→FULL when an accept raises fill_count to S.
- FULL→FILL on out_valid && out_ready: written bitmap cleared, fill_count←0. Bank data is retained; it is not zeroed.
- clear=1: bitmap cleared, fill_count←0, state←FILL. A write accepted in the same cycle as clear is discarded. Bank data is retained.
- out_data always reflects the bank registers, including during FILL; consumers qualify it with out_valid.
- Reset: state FILL, bank all 0, bitmap 0, fill_count 0, addr_err 0. After release: in_ready=1, out_valid=0. Asserting reset mid-frame drops the frame.

## Timing
- All outputs are registered, except in_ready and out_valid, which are decoded directly from the state register.
- A write accepted at edge t appears on out_data and fill_count after edge t.
- The last distinct write at edge t gives out_valid=1 and in_ready=0 after edge t. There is no extra latency.
- A drain handshake at edge t gives in_ready=1 after t. The earliest next accept is edge t+1.
- Minimum frame period is S+1 cycles: S writes plus 1 drain cycle.
- In FULL, out_data and out_valid are held unchanged for any duration of out_ready=0.
- No simultaneous write and drain can occur, because in_ready=0 in FULL.

## Test plan
- Reset/idle: hold rst_n=0 mid-operation, then release → in_ready=1, out_valid=0, fill_count=0, out_data=0.
- In-order fill (N=8, S=4): write 0x11,0x22,0x33,0x44 to addresses 0..3 back-to-back → out_valid rises the cycle after the 4th write; out_data=0x44332211.
- Out-of-order with duplicate (S=4): write addr 2=0xAA, addr 2=0xBB, then 0,1,3 → fill_count sequence 1,1,2,3,4; slot 2=0xBB; out_valid after the 5th accept.
- Backpressure: full buffer, out_ready=0 for 10 cycles with in_valid=1 and changing in_data → in_ready=0, out_data unchanged; out_ready=1 → in_ready=1 next cycle, fill_count=0.
- Clear mid-fill (S=4): 2 writes, then clear together with in_valid=1 → fill_count=0 and that write is discarded; 4 further writes are needed before out_valid.
- Invalid address (S=5, AW=3): write addr 6 → addr_err pulses for 1 cycle, fill_count unchanged; out_data slots 5..7 remain 0.

Source files
------------

// File: rtl/ntt_scatter_buffer_if.sv
// Handshake bundle for the scatter buffer: addressed write side and
// packed-vector read side.
interface ntt_scatter_buffer_if #(
    parameter int N = 64,
    parameter int S = 64
);
    localparam int AW = (S > 1) ? $clog2(S) : 1;
    localparam int P  = 1 << AW;

    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_addr;
    logic [N-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [P*N-1:0]  out_data;
    logic [AW:0]     fill_count;
    logic            addr_err;

    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_data, fill_count, addr_err
    );

    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_data, fill_count, addr_err
    );
endinterface

// File: rtl/ntt_scatter_buffer.sv
// Scatter buffer: assembles a packed S-word bank from individually
// addressed coefficient writes and presents it once every slot is filled.
module ntt_scatter_buffer #(
    parameter int N = 64,
    parameter int S = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    ntt_scatter_buffer_if.slave bus
);
    localparam int AW = (S > 1) ? $clog2(S) : 1;
    localparam int P  = 1 << AW;

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t       state, state_nx;
    logic [N-1:0] bank [S];
    logic [P-1:0] written;
    logic [AW:0]  count;
    logic         err_q;

    logic accept, addr_ok, hit, fresh, drain;

    assign addr_ok = ({1'b0, bus.in_addr} < (AW+1)'(S));
    assign accept  = bus.in_valid && (state == FILL);
    assign hit     = accept && addr_ok && !clear;
    assign fresh   = hit && !written[bus.in_addr];
    assign drain   = (state == FULL) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = FILL;
        end else begin
            unique case (state)
                FILL: if (fresh && count == (AW+1)'(S-1)) state_nx = FULL;
                FULL: if (bus.out_ready) state_nx = FILL;
                default: state_nx = FILL;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == FILL);
        bus.out_valid = (state == FULL);
    end

    // Drain and clear only reset fill tracking; bank contents persist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
            count   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !addr_ok && !clear;
            if (clear || drain) begin
                written <= '0;
                count   <= '0;
            end else if (fresh) begin
                written[bus.in_addr] <= 1'b1;
                count <= count + (AW+1)'(1);
            end
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_bank
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                bank[k] <= '0;
            else if (hit && bus.in_addr == AW'(k))
                bank[k] <= bus.in_data;
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_out
        if (k < S) begin : g_slot
            assign bus.out_data[N*k +: N] = bank[k];
        end else begin : g_pad
            assign bus.out_data[N*k +: N] = '0;
        end
    end

    assign bus.fill_count = count;
    assign bus.addr_err   = err_q;
endmodule

// File: tb/tb_ntt_scatter_buffer.sv
// Directed bench for ntt_scatter_buffer: an S=4 instance for fill, drain,
// backpressure and clear, and an S=5 instance for out-of-range addresses.
module tb_ntt_scatter_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear4 = 1'b0;
    logic clear5 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ntt_scatter_buffer_if #(.N(8), .S(4)) b4 ();
    ntt_scatter_buffer_if #(.N(8), .S(5)) b5 ();

    ntt_scatter_buffer #(.N(8), .S(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clear(clear4), .bus(b4)
    );
    ntt_scatter_buffer #(.N(8), .S(5)) u5 (
        .clk(clk), .rst_n(rst_n), .clear(clear5), .bus(b5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr4(input logic [1:0] a, input logic [7:0] d);
        b4.in_valid = 1'b1;
        b4.in_addr  = a;
        b4.in_data  = d;
        tick();
        b4.in_valid = 1'b0;
    endtask

    task automatic wr5(input logic [2:0] a, input logic [7:0] d);
        b5.in_valid = 1'b1;
        b5.in_addr  = a;
        b5.in_data  = d;
        tick();
        b5.in_valid = 1'b0;
    endtask

    task automatic drain4();
        b4.out_ready = 1'b1;
        tick();
        b4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        wr4(2'd0, 8'h5A);
        wr4(2'd1, 8'hA5);
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (b4.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", b4.in_ready);
        end
        n_chk++;
        if (b4.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", b4.out_valid);
        end
        n_chk++;
        if (b4.fill_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fill: got %0d want 0", b4.fill_count);
        end
        n_chk++;
        if (b4.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data4: got %h want 0", b4.out_data);
        end
        n_chk++;
        if (b5.out_data !== 64'h0 || b5.addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_s5: got %h/%b want 0/0",
                     b5.out_data, b5.addr_err);
        end
    endtask

    task automatic test_in_order();
        wr4(2'd0, 8'h11);
        wr4(2'd1, 8'h22);
        wr4(2'd2, 8'h33);
        n_chk++;
        if (b4.out_valid !== 1'b0 || b4.fill_count !== 3'd3) begin
            n_fail++;
            $display("FAIL inorder_3: got v=%b c=%0d want v=0 c=3",
                     b4.out_valid, b4.fill_count);
        end
        wr4(2'd3, 8'h44);
        n_chk++;
        if (b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_full: got v=%b r=%b want v=1 r=0",
                     b4.out_valid, b4.in_ready);
        end
        n_chk++;
        if (b4.out_data !== 32'h44332211) begin
            n_fail++;
            $display("FAIL inorder_data: got %h want 44332211", b4.out_data);
        end
        drain4();
        n_chk++;
        if (b4.in_ready !== 1'b1 || b4.fill_count !== 3'd0) begin
            n_fail++;
            $display("FAIL inorder_drain: got r=%b c=%0d want r=1 c=0",
                     b4.in_ready, b4.fill_count);
        end
        n_chk++;
        if (b4.out_data !== 32'h44332211) begin
            n_fail++;
            $display("FAIL inorder_retain: got %h want 44332211",
                     b4.out_data);
        end
    endtask

    task automatic test_duplicate();
        logic [1:0] a [5] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [7:0] d [5] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03};
        logic [2:0] c [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        logic       v [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            wr4(a[i], d[i]);
            n_chk++;
            if (b4.fill_count !== c[i] || b4.out_valid !== v[i]) begin
                n_fail++;
                $display("FAIL dup_step%0d: got c=%0d v=%b want c=%0d v=%b",
                         i, b4.fill_count, b4.out_valid, c[i], v[i]);
            end
        end
        n_chk++;
        if (b4.out_data !== 32'h03BB0201) begin
            n_fail++;
            $display("FAIL dup_data: got %h want 03bb0201", b4.out_data);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        b4.out_ready = 1'b0;
        b4.in_valid  = 1'b1;
        b4.in_addr   = 2'd1;
        for (int i = 0; i < 10; i++) begin
            b4.in_data = 8'(8'hE0 + i);
            tick();
            if (b4.in_ready !== 1'b0 || b4.out_valid !== 1'b1 ||
                b4.out_data !== 32'h03BB0201)
                bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d bad cycles want 0 (last %h)",
                     bad, b4.out_data);
        end
        b4.in_valid = 1'b0;
        drain4();
        n_chk++;
        if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 ||
            b4.fill_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_drain: got r=%b v=%b c=%0d want r=1 v=0 c=0",
                     b4.in_ready, b4.out_valid, b4.fill_count);
        end
    endtask

    task automatic test_clear();
        wr4(2'd0, 8'hA0);
        wr4(2'd1, 8'hA1);
        n_chk++;
        if (b4.fill_count !== 3'd2) begin
            n_fail++;
            $display("FAIL clr_pre: got %0d want 2", b4.fill_count);
        end
        clear4 = 1'b1;
        wr4(2'd2, 8'hC2);
        clear4 = 1'b0;
        n_chk++;
        if (b4.fill_count !== 3'd0 || b4.out_data !== 32'h03BBA1A0) begin
            n_fail++;
            $display("FAIL clr_flush: got c=%0d d=%h want c=0 d=03bba1a0",
                     b4.fill_count, b4.out_data);
        end
        wr4(2'd0, 8'hB0);
        wr4(2'd1, 8'hB1);
        wr4(2'd2, 8'hB2);
        n_chk++;
        if (b4.out_valid !== 1'b0 || b4.fill_count !== 3'd3) begin
            n_fail++;
            $display("FAIL clr_3: got v=%b c=%0d want v=0 c=3",
                     b4.out_valid, b4.fill_count);
        end
        wr4(2'd3, 8'hB3);
        n_chk++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== 32'hB3B2B1B0) begin
            n_fail++;
            $display("FAIL clr_full: got v=%b d=%h want v=1 d=b3b2b1b0",
                     b4.out_valid, b4.out_data);
        end
        drain4();
    endtask

    task automatic test_addr_err();
        wr5(3'd6, 8'hFF);
        n_chk++;
        if (b5.addr_err !== 1'b1 || b5.fill_count !== 4'd0) begin
            n_fail++;
            $display("FAIL aerr_pulse: got e=%b c=%0d want e=1 c=0",
                     b5.addr_err, b5.fill_count);
        end
        tick();
        n_chk++;
        if (b5.addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL aerr_drop: got %b want 0", b5.addr_err);
        end
        n_chk++;
        if (b5.out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL aerr_data: got %h want 0", b5.out_data);
        end
        wr5(3'd4, 8'h55);
        n_chk++;
        if (b5.out_data !== 64'h0000_0055_0000_0000 ||
            b5.fill_count !== 4'd1 || b5.addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL aerr_valid: got d=%h c=%0d e=%b want d=0000005500000000 c=1 e=0",
                     b5.out_data, b5.fill_count, b5.addr_err);
        end
    endtask

    initial begin
        b4.in_valid = 1'b0; b4.in_addr = '0; b4.in_data = '0;
        b4.out_ready = 1'b0;
        b5.in_valid = 1'b0; b5.in_addr = '0; b5.in_data = '0;
        b5.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_in_order();
        test_duplicate();
        test_backpressure();
        test_clear();
        test_addr_err();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
